// File: rtl/sparq_cmd_dispatcher_pkg.sv
// Shared types for the host command dispatcher: host/status port layouts, engine
// descriptor, dispatcher states and the command-code decoder.
package sparq_cmd_dispatcher_pkg;

  localparam int FSIZE       = 32;
  localparam int CNT_WIDTH   = FSIZE;
  localparam int NUM_ENGINES = 7;

  localparam logic [2:0] ENGINE_PE_RESET    = 3'd0;
  localparam logic [2:0] ENGINE_GEMM        = 3'd1;
  localparam logic [2:0] ENGINE_A_LOAD      = 3'd2;
  localparam logic [2:0] ENGINE_A_META_LOAD = 3'd3;
  localparam logic [2:0] ENGINE_B_LOAD      = 3'd4;
  localparam logic [2:0] ENGINE_C_LOAD      = 3'd5;
  localparam logic [2:0] ENGINE_C_STORE     = 3'd6;

  // Three-phase groups are laid out contiguously in engine order; *1 and *2 follow *0.
  localparam logic [7:0] COMMAND_PE_RESET         = 8'd1;
  localparam logic [7:0] COMMAND_GEMM0            = 8'd2;
  localparam logic [7:0] COMMAND_AXI_A_LOAD0      = 8'd5;
  localparam logic [7:0] COMMAND_AXI_A_META_LOAD0 = 8'd8;
  localparam logic [7:0] COMMAND_AXI_B_LOAD0      = 8'd11;
  localparam logic [7:0] COMMAND_AXI_C_LOAD0      = 8'd14;
  localparam logic [7:0] COMMAND_AXI_C_STORE0     = 8'd17;
  localparam logic [7:0] COMMAND_LAST             = 8'd19;

  typedef struct packed {
    logic             valid;
    logic [7:0]       command;
    logic [FSIZE-1:0] data0;
    logic [FSIZE-1:0] data1;
  } CommandDataPort;

  typedef struct packed {
    logic [2:0]            id;
    logic [5:0][FSIZE-1:0] param;
  } EngineDesc;

  typedef logic [7:0][FSIZE-1:0] StatePort;

  typedef enum logic [1:0] {DISP_IDLE, DISP_HAVE0, DISP_HAVE1, DISP_WAIT} disp_state_e;

  typedef enum logic [1:0] {PHASE_0, PHASE_1, PHASE_2, PHASE_SINGLE} cmd_phase_e;

  typedef struct packed {
    logic       known;
    logic [2:0] eng;
    cmd_phase_e phase;
  } cmd_decode_t;

  function automatic cmd_decode_t decode_command(input logic [7:0] code);
    cmd_decode_t d;
    logic [7:0]  rel;
    d.known = 1'b0;
    d.eng   = ENGINE_PE_RESET;
    d.phase = PHASE_0;
    rel     = code - COMMAND_GEMM0;
    if (code == COMMAND_PE_RESET) begin
      d.known = 1'b1;
      d.phase = PHASE_SINGLE;
    end else if (code >= COMMAND_GEMM0 && code <= COMMAND_LAST) begin
      d.known = 1'b1;
      d.eng   = 3'(rel / 8'd3 + 8'd1);
      d.phase = cmd_phase_e'(2'(rel % 8'd3));
    end
    return d;
  endfunction

endpackage

// File: rtl/sparq_cmd_dispatcher.sv
// Collects host command words into engine descriptors, launches engines with a
// one-cycle start pulse, tracks busy/done and exposes status counters.
module sparq_cmd_dispatcher
  import sparq_cmd_dispatcher_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  CommandDataPort         cmd_in,
  output logic                   cmd_ready,
  output logic [NUM_ENGINES-1:0] eng_start,
  output EngineDesc              eng_desc,
  input  logic [NUM_ENGINES-1:0] eng_done,
  output StatePort               state_out
);

  disp_state_e           state_q, state_d;
  cmd_decode_t           dec;
  logic                  accept, launch, err_pulse;
  logic [2:0]            group_eng_q;
  logic [5:0][FSIZE-1:0] param_q;
  logic [NUM_ENGINES-1:0] busy_q, done_eff, launch_mask;
  logic [CNT_WIDTH-1:0]  issued_q, completed_q, errors_q, done_cnt;
  logic [7:0]            last_cmd_q;

  assign dec    = decode_command(cmd_in.command);
  assign accept = cmd_in.valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DISP_IDLE;
    else     state_q <= state_d;
  end

  // Any out-of-order word aborts the partial group; a fresh phase0 or PE_RESET starts over.
  always_comb begin
    state_d   = state_q;
    err_pulse = 1'b0;
    case (state_q)
      DISP_IDLE, DISP_HAVE0, DISP_HAVE1: begin
        if (accept) begin
          if (dec.known && dec.phase == PHASE_0) begin
            state_d   = DISP_HAVE0;
            err_pulse = (state_q != DISP_IDLE);
          end else if (dec.known && dec.phase == PHASE_SINGLE) begin
            state_d   = DISP_WAIT;
            err_pulse = (state_q != DISP_IDLE);
          end else if (state_q == DISP_HAVE0 && dec.known && dec.phase == PHASE_1 &&
                       dec.eng == group_eng_q) begin
            state_d = DISP_HAVE1;
          end else if (state_q == DISP_HAVE1 && dec.known && dec.phase == PHASE_2 &&
                       dec.eng == group_eng_q) begin
            state_d = DISP_WAIT;
          end else begin
            state_d   = DISP_IDLE;
            err_pulse = 1'b1;
          end
        end
      end
      DISP_WAIT: if (!busy_q[group_eng_q]) state_d = DISP_IDLE;
      default:   state_d = DISP_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = !rst && (state_q != DISP_WAIT);
    launch      = (state_q == DISP_WAIT) && !busy_q[group_eng_q];
    launch_mask = launch ? (NUM_ENGINES'(1) << group_eng_q) : '0;
    done_eff    = eng_done & busy_q;
    done_cnt    = '0;
    for (int i = 0; i < NUM_ENGINES; i++) done_cnt = done_cnt + CNT_WIDTH'(done_eff[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      group_eng_q <= '0;
      param_q     <= '0;
      eng_start   <= '0;
      eng_desc    <= '0;
      busy_q      <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      errors_q    <= '0;
      last_cmd_q  <= '0;
    end else begin
      if (accept) begin
        last_cmd_q <= cmd_in.command;
        if (dec.known) begin
          case (dec.phase)
            PHASE_0: begin
              group_eng_q <= dec.eng;
              param_q[0]  <= cmd_in.data0;
              param_q[1]  <= cmd_in.data1;
            end
            PHASE_1: begin
              param_q[2] <= cmd_in.data0;
              param_q[3] <= cmd_in.data1;
            end
            PHASE_2: begin
              param_q[4] <= cmd_in.data0;
              param_q[5] <= cmd_in.data1;
            end
            default: begin
              group_eng_q <= dec.eng;
              param_q     <= {{4{{FSIZE{1'b0}}}}, cmd_in.data1, cmd_in.data0};
            end
          endcase
        end
      end
      eng_start <= launch_mask;
      if (launch) begin
        eng_desc.id    <= group_eng_q;
        eng_desc.param <= param_q;
      end
      busy_q      <= (busy_q & ~eng_done) | launch_mask;
      issued_q    <= issued_q + CNT_WIDTH'(launch);
      completed_q <= completed_q + done_cnt;
      errors_q    <= errors_q + CNT_WIDTH'(err_pulse);
    end
  end

  always_comb begin
    state_out    = '0;
    state_out[0] = {16'b0, last_cmd_q, state_q != DISP_IDLE, busy_q};
    state_out[1] = issued_q;
    state_out[2] = completed_q;
    state_out[3] = errors_q;
    for (int i = 0; i < 4; i++) state_out[4+i] = eng_desc.param[i];
  end

endmodule
